// File: rtl/pipe_trace_buffer.sv
// Pipeline trace buffer: captures core debug events into a circular buffer drained via valid/ready.
// Optional feature macro: TRACE_TIMESTAMP_EN prepends a free-running cycle stamp to each record.
module pipe_trace_buffer #(
    parameter int PC_W    = 16,
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3,
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W  = STAMP_W + PC_W + DATA_W + RADDR_W + 3,
`else
    localparam int REC_W  = PC_W + DATA_W + RADDR_W + 3,
`endif
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_W-1:0]    dbg_pc,
    input  logic               dbg_wb_en,
    input  logic [RADDR_W-1:0] dbg_wb_addr,
    input  logic [DATA_W-1:0]  dbg_wb_data,
    input  logic               dbg_stall,
    input  logic               dbg_flush,
    input  logic               arm,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic               wrap_mode,
    input  logic               stop,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [REC_W-1:0]   rd_data,
    output logic [CNT_W-1:0]   count,
    output logic [7:0]         drop_cnt,
    output logic [1:0]         state
);

    localparam int PTR_W = $clog2(DEPTH);

    // Read port handshake: a record is consumed on a rising edge where
    // rd_valid & rd_ready; rd_valid never depends on rd_ready.

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STAMP_W < 1) begin : g_bad_param
        $error("pipe_trace_buffer: DEPTH must be a power of two >= 2 and STAMP_W >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    trig_pc_q, trig_pc_d;
    logic               wrap_q, wrap_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         drop_q, drop_d;
    logic [REC_W-1:0]   mem_q [DEPTH];

    logic               trig_hit;
    logic               capturing;
    logic               event_v;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               overwrite;
    logic               drop_inc;
    logic               mem_we;
    logic [REC_W-1:0]   rec;

`ifdef TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0] stamp_q, stamp_d;

    always_comb begin
        stamp_d = stamp_q + STAMP_W'(1);
        rec     = {stamp_q, dbg_pc, dbg_wb_data, dbg_wb_addr, dbg_wb_en, dbg_stall, dbg_flush};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stamp_q <= '0;
        else        stamp_q <= stamp_d;
    end
`else
    always_comb begin
        rec = {dbg_pc, dbg_wb_data, dbg_wb_addr, dbg_wb_en, dbg_stall, dbg_flush};
    end
`endif

    // The trigger cycle itself is evaluated as an event.
    assign trig_hit  = (state_q == S_ARMED) && (dbg_pc == trig_pc_q) && !dbg_stall;
    assign capturing = !arm && ((state_q == S_CAPTURE) || trig_hit);
    assign event_v   = capturing && (dbg_wb_en || dbg_stall || dbg_flush);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign pop       = !arm && rd_ready && !empty;

    // A pop frees a slot first, so push+pop while full is a normal exchange.
    assign push      = event_v && (!full || pop || wrap_q);
    assign overwrite = event_v && full && !pop && wrap_q;
    assign drop_inc  = event_v && full && !pop;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = trig_en ? S_ARMED : S_CAPTURE;
        end else begin
            case (state_q)
                S_ARMED:   if (trig_hit) state_d = S_CAPTURE;
                S_CAPTURE: if (stop)     state_d = S_DONE;
                default:   state_d = state_q;
            endcase
        end
    end

    // FSM and read-port outputs
    always_comb begin
        state    = state_q;
        rd_valid = !empty;
        rd_data  = mem_q[rd_ptr_q];
        count    = count_q;
        drop_cnt = drop_q;
    end

    // Buffer pointers, occupancy and drop counter
    always_comb begin
        trig_pc_d = trig_pc_q;
        wrap_d    = wrap_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        drop_d    = drop_q;
        mem_we    = 1'b0;
        if (arm) begin
            trig_pc_d = trig_pc;
            wrap_d    = wrap_mode;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            drop_d    = '0;
        end else begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop || overwrite) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !overwrite && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (drop_inc && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_pc_q <= '0;
            wrap_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            drop_q    <= '0;
        end else begin
            trig_pc_q <= trig_pc_d;
            wrap_q    <= wrap_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= rec;
    end

endmodule
